// File: rtl/serial_pkg.sv
// serial_pkg: definitions shared by the serial transmitter and receiver.
//   - FSM state codes (3 bits, also shown on the db_estado debug port)
//   - calc_cpb():     clock cycles per bit, CLOCK_HZ / BAUD_RATE truncated
//   - largura_bits(): width of a counter that must hold 0..n_bits
package serial_pkg;

  typedef logic [2:0] estado_t;

  localparam logic [2:0] INICIAL  = 3'd0;
  localparam logic [2:0] PARTIDA  = 3'd1;
  localparam logic [2:0] DADOS    = 3'd2;
  localparam logic [2:0] PARIDADE = 3'd3;
  localparam logic [2:0] PARADA   = 3'd4;
  localparam logic [2:0] FINAL    = 3'd5;

  function automatic int calc_cpb(input int clock_hz, input int baud_rate);
    return clock_hz / baud_rate;
  endfunction

  function automatic int largura_bits(input int n_bits);
    return $clog2(n_bits + 1);
  endfunction

endpackage

// File: rtl/contador_tick.sv
// contador_tick: free-running modulo-M counter used to time one bit period.
//   clock    in  system clock, rising edge
//   reset    in  asynchronous, active-low reset
//   zera     in  synchronous clear (has priority over conta)
//   conta    in  count enable
//   fim_tick out high in the last cycle of each M-cycle period while counting
// The counter wraps 0..M-1 on its own, so consecutive bit periods never drift.
module contador_tick #(
  parameter int M = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim_tick
);

  localparam int W = (M > 1) ? $clog2(M) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (zera) begin
      cnt <= '0;
    end else if (conta) begin
      if (cnt == W'(M - 1)) cnt <= '0;
      else                  cnt <= cnt + 1'b1;
    end
  end

  assign fim_tick = conta && (cnt == W'(M - 1));

endmodule

// File: rtl/tx_serial.sv
// tx_serial: UART-style transmitter, LSB first.
// Frame: start bit (0), N_BITS data bits, optional parity bit, STOP_BITS stop
// bits (1), each held CPB = CLOCK_HZ/BAUD_RATE clock cycles; then a one-cycle
// fim pulse.
//   clock     in  system clock, rising edge
//   reset     in  asynchronous, active-low reset
//   partida   in  transmit request, accepted only while pronto is high
//   dados     in  [N_BITS-1:0] word, captured when partida is accepted
//   txd       out serial line, idle high
//   pronto    out high when a request will be accepted (INICIAL only)
//   fim       out one-cycle end-of-frame pulse (FINAL state)
//   db_estado out [2:0] current FSM state code
// Build option: define TX_SERIAL_PARITY_EN to insert a parity bit after the
// data bits (PARITY=1 odd, PARITY=0 even). Without it the frame goes straight
// from the data bits to the stop bits.
module tx_serial #(
  parameter int BAUD_RATE = 9600,
  parameter int CLOCK_HZ  = 50_000_000,
  parameter int N_BITS    = 8,
  parameter int PARITY    = 1,
  parameter int STOP_BITS = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              partida,
  input  logic [N_BITS-1:0] dados,
  output logic              txd,
  output logic              pronto,
  output logic              fim,
  output logic [2:0]        db_estado
);

  import serial_pkg::*;

  localparam int   CPB       = calc_cpb(CLOCK_HZ, BAUD_RATE);
  localparam int   BW        = largura_bits(N_BITS);
  localparam logic PAR_IMPAR = (PARITY != 0);

`ifdef TX_SERIAL_PARITY_EN
  localparam logic [2:0] APOS_DADOS = PARIDADE;
`else
  localparam logic [2:0] APOS_DADOS = PARADA;
`endif

  estado_t           estado;
  estado_t           prox;
  logic [N_BITS-1:0] sreg;
  logic [BW-1:0]     nbit;
  logic              par_bit;
  logic              tick;
  logic              conta;
  logic              ultimo_dado;
  logic              ultima_parada;

  // The tick counter runs only while a bit is on the line; it is held at zero
  // in INICIAL and FINAL so every frame starts on a fresh bit period.
  assign conta = (estado == PARTIDA) || (estado == DADOS) ||
                 (estado == PARIDADE) || (estado == PARADA);

  contador_tick #(.M(CPB)) u_tick (
    .clock    (clock),
    .reset    (reset),
    .zera     (!conta),
    .conta    (conta),
    .fim_tick (tick)
  );

  // nbit counts data bits in DADOS and is reused to count stop bits in PARADA.
  assign ultimo_dado   = (nbit == BW'(N_BITS - 1));
  assign ultima_parada = (nbit == BW'(STOP_BITS - 1));

  always_comb begin
    prox = estado;
    case (estado)
      INICIAL:  if (partida)                prox = PARTIDA;
      PARTIDA:  if (tick)                   prox = DADOS;
      DADOS:    if (tick && ultimo_dado)    prox = APOS_DADOS;
      PARIDADE: if (tick)                   prox = PARADA;
      PARADA:   if (tick && ultima_parada)  prox = FINAL;
      FINAL:                                prox = INICIAL;
      default:                              prox = INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado  <= INICIAL;
      sreg    <= '0;
      nbit    <= '0;
      par_bit <= 1'b0;
    end else begin
      estado <= prox;
      case (estado)
        INICIAL: begin
          if (partida) begin
            sreg    <= dados;
            nbit    <= '0;
            // Parity comes from the accepted word, so later dados changes
            // cannot alter the bit in flight.
            par_bit <= PAR_IMPAR ? ~^dados : ^dados;
          end
        end
        DADOS: begin
          if (tick) begin
            sreg <= sreg >> 1;
            nbit <= ultimo_dado ? '0 : nbit + 1'b1;
          end
        end
        PARADA: begin
          if (tick) nbit <= ultima_parada ? '0 : nbit + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Moore outputs; the async reset forces INICIAL, so the line goes high at once.
  always_comb begin
    txd    = 1'b1;
    pronto = 1'b0;
    fim    = 1'b0;
    case (estado)
      INICIAL:  pronto = 1'b1;
      PARTIDA:  txd    = 1'b0;
      DADOS:    txd    = sreg[0];
      PARIDADE: txd    = par_bit;
      FINAL:    fim    = 1'b1;
      default: ;
    endcase
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_tx_serial.sv
// tb_tx_serial: self-checking bench for tx_serial with CLOCK_HZ=80, BAUD_RATE=10
// (CPB=8). dut: 1 stop bit, odd parity. dut2: 2 stop bits, even parity, read
// back by a behavioural receiver. Works with or without TX_SERIAL_PARITY_EN.
`timescale 1ns/1ps
module tb_tx_serial;

  localparam int CLK_HZ = 80;
  localparam int BAUD   = 10;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int NB     = 8;
`ifdef TX_SERIAL_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FB1 = 1 + NB + PB + 1;
  localparam int FB2 = 1 + NB + PB + 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       partida = 1'b0;
  logic [7:0] dados = 8'h00;
  logic       txd, pronto, fim;
  logic [2:0] db_estado;
  logic       partida2 = 1'b0;
  logic [7:0] dados2 = 8'h00;
  logic       txd2, pronto2, fim2;
  logic [2:0] db_estado2;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  tx_serial #(.BAUD_RATE(BAUD), .CLOCK_HZ(CLK_HZ), .N_BITS(NB),
              .PARITY(1), .STOP_BITS(1)) dut (
    .clock(clock), .reset(reset), .partida(partida), .dados(dados),
    .txd(txd), .pronto(pronto), .fim(fim), .db_estado(db_estado));

  tx_serial #(.BAUD_RATE(BAUD), .CLOCK_HZ(CLK_HZ), .N_BITS(NB),
              .PARITY(0), .STOP_BITS(2)) dut2 (
    .clock(clock), .reset(reset), .partida(partida2), .dados(dados2),
    .txd(txd2), .pronto(pronto2), .fim(fim2), .db_estado(db_estado2));

  typedef struct {
    logic [7:0] dados;
    logic       par_impar;
  } vec_t;
  vec_t tab [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the frame as a list of bit periods.
  function automatic logic model_parity(input logic [7:0] w, input bit odd);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(w[i]);
    return odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  function automatic logic model_line(input logic [7:0] w, input logic par, input int b);
    if (b == 0)                  return 1'b0;
    if (b <= NB)                 return w[b-1];
    if (PB == 1 && b == NB + 1)  return par;
    return 1'b1;
  endfunction

  function automatic int model_state(input int b);
    if (b == 0)                  return 1;
    if (b <= NB)                 return 2;
    if (PB == 1 && b == NB + 1)  return 3;
    return 4;
  endfunction

  // Caller has set partida=1 just after a negedge while dut is idle.
  task automatic check_frame(input logic [7:0] w, input logic par, input int pulse_at,
                             input bit keep, input string tag);
    @(posedge clock); #1;
    if (!keep) begin
      partida = 1'b0;
      dados   = 8'($urandom);
    end
    for (int i = 0; i < FB1 * CPB; i++) begin
      @(negedge clock);
      chk({tag, " txd"},    32'(txd),       32'(model_line(w, par, i / CPB)));
      chk({tag, " estado"}, 32'(db_estado), 32'(model_state(i / CPB)));
      chk({tag, " pronto"}, 32'(pronto),    32'd0);
      chk({tag, " fim"},    32'(fim),       32'd0);
      if (!keep) partida = (i == pulse_at);
    end
    @(negedge clock);
    chk({tag, " fim pulse"},   32'(fim),       32'd1);
    chk({tag, " final state"}, 32'(db_estado), 32'd5);
    chk({tag, " final txd"},   32'(txd),       32'd1);
    chk({tag, " final pronto"},32'(pronto),    32'd0);
    @(negedge clock);
    chk({tag, " idle fim"},    32'(fim),       32'd0);
    chk({tag, " idle state"},  32'(db_estado), 32'd0);
    chk({tag, " idle txd"},    32'(txd),       32'd1);
    chk({tag, " idle pronto"}, 32'(pronto),    32'd1);
  endtask

  // Behavioural receiver on txd2: samples each bit near mid-period.
  task automatic loopback(input logic [7:0] w);
    logic [7:0] rx;
    logic       rx_par;
    int         t;
    rx = 8'h00;
    rx_par = 1'b0;
    @(negedge clock);
    partida2 = 1'b1;
    dados2   = w;
    @(posedge clock); #1;
    partida2 = 1'b0;
    dados2   = 8'($urandom);
    t = 0;
    @(negedge clock);
    while (txd2 !== 1'b0 && t < 4 * CPB) begin
      @(negedge clock);
      t++;
    end
    chk("lb start seen", 32'(t < 4 * CPB), 32'd1);
    repeat (CPB / 2 - 1) @(negedge clock);
    chk("lb start bit", 32'(txd2), 32'd0);
    for (int b = 0; b < NB; b++) begin
      repeat (CPB) @(negedge clock);
      rx[b] = txd2;
    end
`ifdef TX_SERIAL_PARITY_EN
    repeat (CPB) @(negedge clock);
    rx_par = txd2;
    chk("lb even parity", 32'(^{rx, rx_par}), 32'd0);
`endif
    for (int s = 0; s < 2; s++) begin
      repeat (CPB) @(negedge clock);
      chk("lb stop bit", 32'(txd2), 32'd1);
    end
    chk("lb word", 32'(rx), 32'(w));
    t = 0;
    while (fim2 !== 1'b1 && t < 3 * CPB) begin
      @(negedge clock);
      t++;
    end
    chk("lb fim seen", 32'(fim2), 32'd1);
    chk("lb fim timing", 32'(t), 32'(CPB / 2 + 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tab[0] = '{8'h55, 1'b1};
    tab[1] = '{8'h07, 1'b0};
    tab[2] = '{8'h00, 1'b1};
    tab[3] = '{8'hFF, 1'b1};
    tab[4] = '{8'hA3, 1'b1};
    tab[5] = '{8'h80, 1'b0};

    // Reset state, with partida asserted during reset
    reset = 1'b0; partida = 1'b1; dados = 8'hFF; partida2 = 1'b1; dados2 = 8'hFF;
    repeat (3) @(negedge clock);
    chk("rst txd",    32'(txd),       32'd1);
    chk("rst pronto", 32'(pronto),    32'd1);
    chk("rst fim",    32'(fim),       32'd0);
    chk("rst estado", 32'(db_estado), 32'd0);
    chk("rst txd2",   32'(txd2),      32'd1);
    partida = 1'b0; partida2 = 1'b0; reset = 1'b1;
    @(negedge clock);
    chk("post rst estado", 32'(db_estado), 32'd0);
    chk("post rst pronto", 32'(pronto),    32'd1);

    // Table-driven frames
    foreach (tab[i]) begin
      @(negedge clock);
      partida = 1'b1;
      dados   = tab[i].dados;
      check_frame(tab[i].dados, tab[i].par_impar, -1, 1'b0, $sformatf("tab%0d", i));
    end

    // Request while busy is ignored
    @(negedge clock);
    partida = 1'b1; dados = 8'h3C;
    check_frame(8'h3C, model_parity(8'h3C, 1'b1), 30, 1'b0, "busy");
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      chk("busy no 2nd frame estado", 32'(db_estado), 32'd0);
      chk("busy no 2nd frame txd",    32'(txd),       32'd1);
    end

    // Back-to-back with partida held high
    @(negedge clock);
    partida = 1'b1; dados = 8'h5A;
    check_frame(8'h5A, model_parity(8'h5A, 1'b1), -1, 1'b1, "b2b_a");
    dados = 8'hC3;
    check_frame(8'hC3, model_parity(8'hC3, 1'b1), -1, 1'b0, "b2b_b");

    // Reset during data bit 3
    @(negedge clock);
    partida = 1'b1; dados = 8'hF8;
    @(posedge clock); #1;
    partida = 1'b0;
    repeat (4 * CPB + 3) @(negedge clock);
    chk("mid estado", 32'(db_estado), 32'd2);
    chk("mid txd",    32'(txd),       32'd1);
    reset = 1'b0;
    #1;
    chk("mid rst txd",    32'(txd),       32'd1);
    chk("mid rst pronto", 32'(pronto),    32'd1);
    chk("mid rst estado", 32'(db_estado), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("mid rst no fim", 32'(fim), 32'd0);
    end
    reset = 1'b1;
    @(negedge clock);
    partida = 1'b1; dados = 8'hA3;
    check_frame(8'hA3, 1'b1, -1, 1'b0, "after rst");

    // Randomized frames against the model
    for (int n = 0; n < 8; n++) begin
      logic [7:0] w;
      w = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clock);
      @(negedge clock);
      partida = 1'b1; dados = w;
      check_frame(w, model_parity(w, 1'b1), -1, 1'b0, $sformatf("rnd%0d", n));
    end

    // Loopback through the behavioural receiver, 2 stop bits, even parity
    loopback(8'h00);
    loopback(8'hFF);
    loopback(8'hA3);
    loopback(8'h07);
    for (int n = 0; n < 4; n++) loopback(8'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tx_serial.md
# tx_serial

Asynchronous serial (UART-style) transmitter: the upstream counterpart of the team's serial receiver, whose `txd` output drives the receiver's `rxd` input. It accepts one N_BITS word per request and serialises it LSB-first:

- start bit, data bits, optional parity bit, then stop bit(s), each held for one bit period derived from CLOCK_HZ/BAUD_RATE;
- a one-cycle `fim` pulse marks the end of each frame.

## Interface
- BAUD_RATE, 9600, line bit rate in bits/s
- CLOCK_HZ, 50_000_000, frequency of `clock` in Hz
- N_BITS, 8, data bits per frame (1..16)
- PARITY, 1, 1 = odd parity, 0 = even parity (only meaningful with TX_SERIAL_PARITY_EN)
- STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
- clock  in  1  system clock, single clock domain, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- partida  in  1  transmit request, level-sampled each cycle
- dados  in  N_BITS  word to send, captured in the cycle `partida` is accepted
- txd  out  1  serial line, idle high
- pronto  out  1  high when a new `partida` will be accepted
- fim  out  1  one-cycle pulse at end of frame
- db_estado  out  3  current FSM state code, for debug displays

## Operation
- CPB = CLOCK_HZ / BAUD_RATE, integer division, truncated; CPB ≥ 2 required.
- FSM states and codes:
  - INICIAL 0
  - PARTIDA 1
  - DADOS 2
  - PARIDADE 3
  - PARADA 4
  - FINAL 5
  - codes 6 and 7 are unused and return to INICIAL on the next clock.
- INICIAL:
  - outputs: `txd`=1, `pronto`=1.
  - transition: `partida`=1 → latch `dados` into the shift register, clear the tick counter, go to PARTIDA.
- PARTIDA: `txd`=0 for CPB cycles → DADOS.
- DADOS:
  - `txd` = shift register bit 0; the register shifts right after each CPB cycles;
  - after N_BITS bits → PARIDADE if parity is enabled, else PARADA.
- PARIDADE:
  - `txd` = parity bit, computed from the latched word (not from live `dados`), held CPB cycles → PARADA;
  - odd parity: bit = ~^word;
  - even parity: bit = ^word.
- PARADA: `txd`=1 for STOP_BITS×CPB cycles → FINAL.
- FINAL:
  - outputs: `txd`=1, `fim`=1, `pronto`=0;
  - exactly one cycle → INICIAL.
- `pronto` is 0 in every state except INICIAL.
- `partida` outside INICIAL is ignored, not queued.
- Changes to `dados` after acceptance have no effect on the frame in flight.

## Timing
- Reset values (asynchronous, immediate): `txd`=1, `pronto`=1, `fim`=0, `db_estado`=0, FSM=INICIAL, counters and shift register cleared.
- Reset asserted mid-frame: the line returns high immediately and the frame is abandoned; no `fim` pulse.
- Acceptance: `partida`=1 sampled at edge k while in INICIAL → `txd`=0 from edge k onward (start bit visible in cycle k+1).
- Frame length from start-bit edge to stop-bit end: (1 + N_BITS + P + STOP_BITS)×CPB cycles, where P is 1 with parity, 0 without.
- `fim` is high for the single cycle following the last stop-bit cycle.
- Back-to-back frames:
  - `partida` held high through FINAL is accepted in INICIAL on the next edge;
  - minimum inter-frame gap is 1 cycle (FINAL) + 1 cycle (INICIAL) of idle-high line.
- Every bit is held exactly CPB cycles, with no cumulative drift; the tick counter wraps 0..CPB-1.

## Configuration
- TX_SERIAL_PARITY_EN defined:
  - the PARIDADE state is used; PARITY selects odd or even;
  - the frame is 1 + N_BITS + 1 + STOP_BITS bits.
- TX_SERIAL_PARITY_EN undefined:
  - PARIDADE is never entered (DADOS → PARADA); PARITY is ignored;
  - the frame is 1 + N_BITS + STOP_BITS bits.

## Structure
- Package `serial_pkg`, shared with the receiver:
  - FSM state encoding constants;
  - a CPB computation function;
  - bit-counter width function, clog2(N_BITS+1).
- One sub-module: `contador_tick`, a parameterised modulo-CPB counter with `zera` and `conta` inputs and a `fim_tick` output, reusable by the receiver.
- Control (FSM) and datapath (shift register, bit counter, parity) live in `tx_serial`.

## Test plan
Benches run with CLOCK_HZ=80, BAUD_RATE=10, i.e. CPB=8.

- Reset state: with reset low → `txd`=1, `pronto`=1, `fim`=0, `db_estado`=0; asserting `partida` during reset has no effect.
- Odd parity, `dados`=8'h55 (4 ones), parity enabled → line sequence 0,1,0,1,0,1,0,1,0,1(parity),1(stop), each bit 8 cycles; `fim` 1 cycle after 88 cycles.
- Even parity, `dados`=8'h07 → parity bit 1; with TX_SERIAL_PARITY_EN undefined → 10-bit frame, `fim` after 80 cycles.
- Busy and back-to-back:
  - `partida` pulsed mid-frame → ignored, a single frame only;
  - `partida` held high → second frame's start bit begins 2 cycles after the `fim` cycle.
- Reset mid-frame: reset asserted during DADOS bit 3 → `txd`=1 at once, no `fim`; after release, a new frame with 8'hA3 is sent correctly.
- Loopback: `txd` wired to the receiver's `rxd`, with STOP_BITS=2 and words 8'h00, 8'hFF, 8'hA3 → the receiver's data matches each word and its parity check passes.
